// File: rtl/video_timing_ctrl.sv
// Raster timing generator with frame-synchronous test-pattern scheduling.
// Counters h/v are decoded and registered together, so every output shares one cycle of latency.
module video_timing_ctrl #(
  parameter int H_ACTIVE       = 1280,
  parameter int H_FP           = 110,
  parameter int H_SYNC         = 40,
  parameter int H_BP           = 220,
  parameter int V_ACTIVE       = 720,
  parameter int V_FP           = 5,
  parameter int V_SYNC         = 5,
  parameter int V_BP           = 20,
  parameter bit SYNC_POL       = 1'b1,
  parameter int NUM_PAT        = 4,
  parameter int FRAMES_PER_PAT = 120
) (
  input  logic        rfr_clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        auto_cycle,
  input  logic        pat_next,
  output logic [11:0] pixel_cnt,
  output logic [11:0] line_cnt,
  output logic        video_on,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic [1:0]  pat_sel
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FCW     = ($clog2(FRAMES_PER_PAT) > 7) ? $clog2(FRAMES_PER_PAT) : 7;

  localparam logic [11:0]    H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0]    V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0]    H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0]    V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0]    HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0]    HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0]    VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0]    VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [FCW-1:0] FC_LAST  = FCW'(FRAMES_PER_PAT - 1);
  localparam logic [1:0]     PAT_LAST = 2'(NUM_PAT - 1);

  logic [11:0]    h_q, h_d, v_q, v_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic           pend_q, pend_d;
  logic           adv_q, adv_d;
  logic [1:0]     pat_sel_q, pat_sel_d;

  logic [11:0]    pixel_cnt_q, pixel_cnt_d, line_cnt_q, line_cnt_d;
  logic           video_on_q, video_on_d;
  logic           hsync_q, hsync_d, vsync_q, vsync_d;
  logic           frame_start_q, frame_start_d;

  logic           h_end, v_end, boundary, advance, hs_win, vs_win;

  always_comb begin
    h_end    = (h_q == H_LAST);
    v_end    = (v_q == V_LAST);
    boundary = enable && h_end && v_end;

    h_d = '0;
    v_d = '0;
    if (enable) begin
      h_d = h_end ? '0 : h_q + 12'd1;
      v_d = v_q;
      if (h_end) v_d = v_end ? '0 : v_q + 12'd1;
    end

    // Decision is taken on the last pixel of the frame; the index itself moves one
    // edge later so that it lands together with the registered (0,0) output.
    advance = boundary && (pend_q || pat_next || (auto_cycle && (frame_cnt_q == FC_LAST)));
    adv_d   = advance;
    pend_d  = advance ? 1'b0 : (pend_q | pat_next);

    frame_cnt_d = frame_cnt_q;
    if (!auto_cycle || advance) frame_cnt_d = '0;
    else if (boundary)          frame_cnt_d = frame_cnt_q + 1'b1;

    pat_sel_d = pat_sel_q;
    if (adv_q) pat_sel_d = (pat_sel_q == PAT_LAST) ? '0 : pat_sel_q + 2'd1;
  end

  always_comb begin
    hs_win = (h_q >= HS_START) && (h_q < HS_END);
    vs_win = (v_q >= VS_START) && (v_q < VS_END);

    pixel_cnt_d   = '0;
    line_cnt_d    = '0;
    video_on_d    = 1'b0;
    hsync_d       = !SYNC_POL;
    vsync_d       = !SYNC_POL;
    frame_start_d = 1'b0;
    if (enable) begin
      pixel_cnt_d   = h_q;
      line_cnt_d    = v_q;
      video_on_d    = (h_q < H_ACT) && (v_q < V_ACT);
      hsync_d       = hs_win ? SYNC_POL : !SYNC_POL;
      vsync_d       = vs_win ? SYNC_POL : !SYNC_POL;
      frame_start_d = (h_q == '0) && (v_q == '0);
    end
  end

  always_ff @(posedge rfr_clk) begin
    if (!reset_n) begin
      h_q           <= '0;
      v_q           <= '0;
      frame_cnt_q   <= '0;
      pend_q        <= 1'b0;
      adv_q         <= 1'b0;
      pat_sel_q     <= '0;
      pixel_cnt_q   <= '0;
      line_cnt_q    <= '0;
      video_on_q    <= 1'b0;
      hsync_q       <= !SYNC_POL;
      vsync_q       <= !SYNC_POL;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      frame_cnt_q   <= frame_cnt_d;
      pend_q        <= pend_d;
      adv_q         <= adv_d;
      pat_sel_q     <= pat_sel_d;
      pixel_cnt_q   <= pixel_cnt_d;
      line_cnt_q    <= line_cnt_d;
      video_on_q    <= video_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pixel_cnt   = pixel_cnt_q;
  assign line_cnt    = line_cnt_q;
  assign video_on    = video_on_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;
  assign pat_sel     = pat_sel_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Scoreboard bench for video_timing_ctrl on a 16x8 raster: a frame-position model
// predicts every registered output and a monitor compares them one edge later.
module tb_video_timing_ctrl;

  localparam int HA = 8, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 4, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam int NP = 4;
  localparam int FPP = 2;
  localparam bit POL = 1'b1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0, enable = 1'b0, auto_cycle = 1'b0, pat_next = 1'b0;
  logic [11:0] pixel_cnt, line_cnt;
  logic        video_on, hsync, vsync, frame_start;
  logic [1:0]  pat_sel;

  video_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(POL), .NUM_PAT(NP), .FRAMES_PER_PAT(FPP)
  ) dut (
    .rfr_clk(clk), .reset_n(reset_n), .enable(enable), .auto_cycle(auto_cycle),
    .pat_next(pat_next), .pixel_cnt(pixel_cnt), .line_cnt(line_cnt),
    .video_on(video_on), .hsync(hsync), .vsync(vsync),
    .frame_start(frame_start), .pat_sel(pat_sel)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] px;
    logic [11:0] ln;
    logic        von;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [1:0]  pat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Model state: position within the frame, frames shown of current pattern,
  // pending manual request, and an advance waiting for the next frame start.
  int   mt = 0;
  int   mfc = 0;
  bit   mpend = 0;
  bit   madv = 0;
  int   mpat = 0;

  task automatic step(input bit r, input bit e, input bit a, input bit p);
    exp_t x;
    bit   bnd;
    int   px, ln;
    @(negedge clk);
    reset_n = r; enable = e; auto_cycle = a; pat_next = p;
    x   = '0;
    bnd = 0;
    if (!r) begin
      mt = 0; mfc = 0; mpend = 0; madv = 0; mpat = 0;
      x.hs = !POL; x.vs = !POL;
    end else begin
      if (madv) begin
        mpat = (mpat + 1) % NP;
        madv = 0;
      end
      if (p) mpend = 1;
      if (e) begin
        px    = mt % HT;
        ln    = mt / HT;
        x.px  = 12'(px);
        x.ln  = 12'(ln);
        x.von = (px < HA) && (ln < VA);
        x.hs  = (px >= HA + HFP && px < HA + HFP + HS) ? POL : !POL;
        x.vs  = (ln >= VA + VFP && ln < VA + VFP + VS) ? POL : !POL;
        x.fs  = (mt == 0);
        bnd   = (mt == FT - 1);
        mt    = (mt + 1) % FT;
      end else begin
        x.hs = !POL; x.vs = !POL;
        mt = 0;
      end
      if (bnd) begin
        if (mpend || (a && mfc == FPP - 1)) begin
          madv = 1; mpend = 0; mfc = 0;
        end else begin
          mfc = a ? mfc + 1 : 0;
        end
      end else if (!a) begin
        mfc = 0;
      end
      x.pat = 2'(mpat);
    end
    sb.push_back(x);
  endtask

  // Advance with fixed controls until the model reaches frame position tgt.
  task automatic run_to(input int tgt, input bit a, input int budget);
    int n;
    n = 0;
    while (mt != tgt && n < budget) begin
      step(1, 1, a, 0);
      n++;
    end
    checks++;
    if (mt != tgt) begin
      errors++;
      $display("FAIL run_to got pos=%0d need pos=%0d", mt, tgt);
    end
  endtask

  always @(posedge clk) begin
    exp_t e, g;
    #1;
    cyc++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      g = '{pixel_cnt, line_cnt, video_on, hsync, vsync, frame_start, pat_sel};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL out cyc=%0d got px=%0d ln=%0d von=%b hs=%b vs=%b fs=%b pat=%0d need px=%0d ln=%0d von=%b hs=%b vs=%b fs=%b pat=%0d",
                 cyc, g.px, g.ln, g.von, g.hs, g.vs, g.fs, g.pat,
                 e.px, e.ln, e.von, e.hs, e.vs, e.fs, e.pat);
      end
    end
  end

  initial begin
    bit a;
    // Reset and free run of two frames.
    repeat (3) step(0, 1, 0, 0);
    repeat (2 * FT) step(1, 1, 0, 0);
    // Automatic advance through a full pattern wrap.
    repeat (9 * FT + 5) step(1, 1, 1, 0);
    // Manual request at (5,2) then three more inside the same frame.
    run_to(2 * HT + 5, 0, 2 * FT);
    step(1, 1, 0, 1);
    repeat (10) step(1, 1, 0, 0);
    step(1, 1, 0, 1);
    repeat (7) step(1, 1, 0, 0);
    step(1, 1, 0, 1);
    step(1, 1, 0, 1);
    repeat (2 * FT) step(1, 1, 0, 0);
    // Manual request on the same boundary as an automatic advance.
    repeat (FT) step(1, 1, 1, 0);
    for (int k = 0; k < 2 * FPP && !(mfc == FPP - 1); k++) repeat (FT) step(1, 1, 1, 0);
    run_to(FT - 1, 1, FT);
    step(1, 1, 1, 1);
    repeat (3 * FT) step(1, 1, 1, 0);
    // Enable dropped mid-line.
    run_to(HT + 6, 0, FT);
    repeat (5) step(1, 0, 0, 0);
    repeat (FT + 20) step(1, 1, 0, 0);
    // Reset while vsync is active.
    run_to(6 * HT + 9, 0, FT);
    step(0, 1, 0, 0);
    repeat (FT) step(1, 1, 1, 0);
    // Randomized controls.
    a = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) a = ~a;
      step($urandom_range(0, 999) != 0, $urandom_range(0, 249) != 0, a,
           $urandom_range(0, 149) == 0);
    end
    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got left=%0d need left=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
